// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: one full-subtractor cell computes a - b - b_in LSB first,
// with a start valid/ready handshake in and a done valid/ready handshake out.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_subtractor_nbit #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic [N-1:0] d,
    output logic         b_out,
`ifdef SERIAL_SUB_OVF_EN
    output logic         ovf,
`endif
    output logic         done_valid,
    input  logic         done_ready
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Full-subtractor cell: returns {borrow_out, diff}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic c);
        logic diff;
        logic bor;
        diff = x ^ y ^ c;
        bor  = (~x & y) | (~(x ^ y) & c);
        return {bor, diff};
    endfunction

    state_e          state_q;
    logic [N-1:0]    a_sr_q;
    logic [N-1:0]    b_sr_q;
    logic [N-2:0]    res_sr_q;
    logic [CW-1:0]   cnt_q;
    logic            borrow_q;
    logic [N-1:0]    d_q;
    logic            b_out_q;
    logic            done_valid_q;
    logic            start_ready_q;
`ifdef SERIAL_SUB_OVF_EN
    logic            ovf_q;
    logic            ovf_d;
`endif

    logic [1:0]      cell_s;
    logic            diff_d;
    logic            borrow_d;
    logic [N-1:0]    res_full_d;
    logic [N-2:0]    res_sr_d;

    // Subtractor cell on the current LSBs and the assembled result including this bit.
    always_comb begin
        cell_s     = full_sub(a_sr_q[0], b_sr_q[0], borrow_q);
        diff_d     = cell_s[0];
        borrow_d   = cell_s[1];
        res_full_d = {diff_d, res_sr_q};
        res_sr_d   = res_full_d[N-1:1];
    end

`ifdef SERIAL_SUB_OVF_EN
    // On the last RUN cycle the shift-register LSBs are the operand sign bits.
    always_comb begin
        ovf_d = (a_sr_q[0] != b_sr_q[0]) && (diff_d != a_sr_q[0]);
    end
`endif

    // Control FSM and datapath registers, all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            a_sr_q        <= '0;
            b_sr_q        <= '0;
            res_sr_q      <= '0;
            cnt_q         <= '0;
            borrow_q      <= 1'b0;
            d_q           <= '0;
            b_out_q       <= 1'b0;
            done_valid_q  <= 1'b0;
            start_ready_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_valid && start_ready_q) begin
                        a_sr_q        <= a;
                        b_sr_q        <= b;
                        borrow_q      <= b_in;
                        res_sr_q      <= '0;
                        cnt_q         <= '0;
                        start_ready_q <= 1'b0;
                        state_q       <= ST_RUN;
                    end else begin
                        start_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    borrow_q <= borrow_d;
                    res_sr_q <= res_sr_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        d_q          <= res_full_d;
                        b_out_q      <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q        <= ovf_d;
`endif
                        done_valid_q <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (done_ready) begin
                        done_valid_q  <= 1'b0;
                        start_ready_q <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    done_valid_q  <= 1'b0;
                    start_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign d           = d_q;
    assign b_out       = b_out_q;
    assign done_valid  = done_valid_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf         = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// Self-checking bench for serial_subtractor_nbit (N=4): directed table, backpressure,
// mid-run reset and randomised back-to-back operations with done_ready stalls.
module tb_serial_subtractor_nbit;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic [N-1:0] d;
    logic         b_out;
    logic         done_valid;
    logic         done_ready;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor_nbit #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .b_in        (b_in),
        .d           (d),
        .b_out       (b_out),
`ifdef SERIAL_SUB_OVF_EN
        .ovf         (ovf),
`endif
        .done_valid  (done_valid),
        .done_ready  (done_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bin;
        logic [N-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Signed overflow of a - b - bin, computed with integer arithmetic.
    function automatic logic ovf_model(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                                       input logic tbin);
        int sa;
        int sb;
        int r;
        sa = int'($signed(ta));
        sb = int'($signed(tb_v));
        r  = sa - sb - int'(tbin);
        return (r < -(2 ** (N - 1))) || (r > (2 ** (N - 1)) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present operands and complete one accept handshake; returns at the negedge after it.
    task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input logic tbin);
        int w;
        w = 0;
        while (start_ready !== 1'b1 && w < 20) begin
            tick();
            w++;
        end
        check("start_ready_before_accept", 32'(start_ready), 32'd1);
        a           = ta;
        b           = tb_v;
        b_in        = tbin;
        start_valid = 1'b1;
        tick();
        start_valid = 1'b0;
        a           = N'($urandom());
        b           = N'($urandom());
        b_in        = 1'($urandom());
        check("start_ready_after_accept", 32'(start_ready), 32'd0);
    endtask

    // Wait for done_valid (called at the negedge after accept) and check latency and result.
    task automatic wait_done(input logic [N-1:0] exp_d, input logic exp_bo, input logic exp_ov);
        int cyc;
        cyc = 0;
        while (done_valid !== 1'b1 && cyc < 50) begin
            check("start_ready_in_run", 32'(start_ready), 32'd0);
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(N));
        check("d", 32'(d), 32'(exp_d));
        check("b_out", 32'(b_out), 32'(exp_bo));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(exp_ov));
`else
        if (exp_ov === 1'bx) $display("unexpected x in overflow expectation");
`endif
    endtask

    // Hold done_ready low for stall cycles, then consume the result.
    task automatic release_done(input int stall, input logic [N-1:0] exp_d, input logic exp_bo);
        done_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall_done_valid", 32'(done_valid), 32'd1);
            check("stall_d", 32'({b_out, d}), 32'({exp_bo, exp_d}));
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("done_valid_after_consume", 32'(done_valid), 32'd0);
        check("start_ready_after_consume", 32'(start_ready), 32'd1);
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        logic         rbi;
        logic [N:0]   m;

        vecs[0]  = '{a: 4'd9,  b: 4'd3,  bin: 1'b0, d: 4'd6,  bo: 1'b0, ov: 1'b1};
        vecs[1]  = '{a: 4'd3,  b: 4'd9,  bin: 1'b0, d: 4'd10, bo: 1'b1, ov: 1'b1};
        vecs[2]  = '{a: 4'd5,  b: 4'd5,  bin: 1'b0, d: 4'd0,  bo: 1'b0, ov: 1'b0};
        vecs[3]  = '{a: 4'd0,  b: 4'd15, bin: 1'b1, d: 4'd0,  bo: 1'b1, ov: 1'b0};
        vecs[4]  = '{a: 4'd8,  b: 4'd0,  bin: 1'b1, d: 4'd7,  bo: 1'b0, ov: 1'b1};
        vecs[5]  = '{a: 4'd7,  b: 4'd15, bin: 1'b0, d: 4'd8,  bo: 1'b1, ov: 1'b1};
        vecs[6]  = '{a: 4'd2,  b: 4'd1,  bin: 1'b0, d: 4'd1,  bo: 1'b0, ov: 1'b0};
        vecs[7]  = '{a: 4'd12, b: 4'd4,  bin: 1'b1, d: 4'd7,  bo: 1'b0, ov: 1'b1};
        vecs[8]  = '{a: 4'd15, b: 4'd15, bin: 1'b1, d: 4'd15, bo: 1'b1, ov: 1'b0};
        vecs[9]  = '{a: 4'd0,  b: 4'd0,  bin: 1'b1, d: 4'd15, bo: 1'b1, ov: 1'b0};
        vecs[10] = '{a: 4'd15, b: 4'd0,  bin: 1'b0, d: 4'd15, bo: 1'b0, ov: 1'b0};

        rst         = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        a           = '0;
        b           = '0;
        b_in        = 1'b0;

        // Reset state.
        tick();
        check("rst_start_ready", 32'(start_ready), 32'd0);
        check("rst_done_valid", 32'(done_valid), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_b_out", 32'(b_out), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("start_ready_after_rst", 32'(start_ready), 32'd1);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
            wait_done(vecs[i].d, vecs[i].bo, vecs[i].ov);
            release_done(i % 3, vecs[i].d, vecs[i].bo);
        end

        // Backpressure with a new request pending throughout.
        start_op(4'd9, 4'd3, 1'b0);
        wait_done(4'd6, 1'b0, ovf_model(4'd9, 4'd3, 1'b0));
        start_valid = 1'b1;
        a           = 4'd2;
        b           = 4'd1;
        b_in        = 1'b0;
        for (int s = 0; s < 5; s++) begin
            tick();
            check("bp_done_valid", 32'(done_valid), 32'd1);
            check("bp_result", 32'({b_out, d}), 32'({1'b0, 4'd6}));
            check("bp_start_ready", 32'(start_ready), 32'd0);
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check("bp_release_done_valid", 32'(done_valid), 32'd0);
        check("bp_release_start_ready", 32'(start_ready), 32'd1);
        check("bp_release_d_held", 32'(d), 32'd6);
        tick();
        start_valid = 1'b0;
        check("bp_accept_start_ready", 32'(start_ready), 32'd0);
        wait_done(4'd1, 1'b0, 1'b0);
        release_done(0, 4'd1, 1'b0);

        // Reset in the middle of RUN discards the operation and clears the result.
        start_op(4'd9, 4'd3, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("midrst_done_valid", 32'(done_valid), 32'd0);
        check("midrst_d", 32'(d), 32'd0);
        check("midrst_b_out", 32'(b_out), 32'd0);
        check("midrst_start_ready", 32'(start_ready), 32'd0);
        rst = 1'b0;
        tick();
        start_op(4'd12, 4'd4, 1'b1);
        wait_done(4'd7, 1'b0, 1'b1);
        release_done(1, 4'd7, 1'b0);

        // Random back-to-back operations with random consumer stalls.
        for (int k = 0; k < 200; k++) begin
            ra  = N'($urandom());
            rb  = N'($urandom());
            rbi = 1'($urandom());
            m   = {1'b0, ra} - {1'b0, rb} - (N + 1)'(rbi);
            start_op(ra, rb, rbi);
            wait_done(m[N-1:0], m[N], ovf_model(ra, rb, rbi));
            release_done(int'($urandom_range(0, 3)), m[N-1:0], m[N]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
Bit-serial N-bit subtractor, the inverse of the team's ripple-carry adder. One full-subtractor cell computes a - b - b_in, LSB first, one bit per clock. Operands enter through a start valid/ready handshake and results leave through a done valid/ready handshake. It targets area-constrained datapaths where one subtract every N+2 cycles is enough.

Parameters:
N, 4, operand/result width in bits; legal range N >= 2

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
start_valid  input  1  operands a, b, b_in are valid this cycle
start_ready  output  1  block can accept operands (high only in IDLE)
a  input  N  minuend, unsigned; sampled only on start handshake
b  input  N  subtrahend, unsigned; sampled only on start handshake
b_in  input  1  borrow-in; sampled only on start handshake
d  output  N  difference, (a - b - b_in) mod 2^N
b_out  output  1  borrow-out; 1 iff a < b + b_in (unsigned)
done_valid  output  1  d/b_out hold a fresh result
done_ready  input  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, d=0, b_out=0, done_valid=0, internal shift registers/counter/borrow=0. start_ready=0 while rst is high, 1 from the first cycle after rst falls.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready: latch a, b into right-shift registers, latch b_in into the borrow flop, clear the bit counter, go to RUN.
- RUN:
  - start_ready=0.
  - Each cycle, with x=a_sr[0], y=b_sr[0], c=borrow: diff = x^y^c; borrow_next = (~x&y) | (~(x^y)&c).
  - diff shifts into the result shift register MSB (shift right); a_sr and b_sr shift right; the counter increments.
  - On the cycle the counter reaches N-1: load d from the assembled result (including the final bit), load b_out from borrow_next, go to DONE.
- DONE:
  - done_valid=1; d and b_out stable.
  - On done_ready: go to IDLE.
  - start_ready stays 0 in DONE, so there is no same-cycle restart; the next accept is possible one cycle later.
- Latency: handshake at edge k gives done_valid=1 after edge k+N. Throughput is one operation per N+2 cycles minimum.
- d and b_out are registered. They hold the last result through IDLE and RUN until the next DONE entry.
- Inputs a, b, b_in are don't-care outside the accept cycle. start_valid is ignored outside IDLE. done_ready is ignored outside DONE.
- Backpressure: DONE holds indefinitely while done_ready=0.
- Reset mid-operation (RUN or DONE): operation discarded. Next cycle is IDLE with all reset values, including d=0.
- Boundary cases:
  - a=b with b_in=0 gives d=0, b_out=0.
  - a=0, b=2^N-1, b_in=1 gives d=0, b_out=1 (full wrap).
- Width rule: {b_out,d} equals the low N+1 bits of ({1'b0,a} - b - b_in).

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Adds output ovf, 1 bit, registered with d.
  - ovf = signed two's-complement overflow of a - b - b_in = (a[N-1]!=b[N-1]) && (d[N-1]!=a[N-1]).
  - Reset value 0; held like d.
- Undefined: port ovf does not exist and no overflow logic is built. All other behaviour is identical.

Test Plan:
1. N=4, a=9, b=3, b_in=0, start at edge k -> done_valid=1 after edge k+4, d=6, b_out=0; start_ready=0 from k+1 until IDLE.
2. a=3, b=9, b_in=0 -> d=10, b_out=1; a=5, b=5, b_in=0 -> d=0, b_out=0; a=0, b=15, b_in=1 -> d=0, b_out=1.
3. Backpressure: done_ready=0 for 5 cycles after done_valid, start_valid=1 with new operands -> d, b_out, done_valid constant and start_ready=0 throughout. done_ready=1 -> IDLE next cycle, then accept.
4. Reset mid-RUN: assert rst 2 cycles after accept -> next cycle state IDLE, done_valid=0, d=0, b_out=0. Following op a=12, b=4, b_in=1 -> d=7, b_out=0.
5. SERIAL_SUB_OVF_EN defined: a=8, b=0, b_in=1 -> d=7, ovf=1; a=7, b=15, b_in=0 -> d=8, ovf=1; a=2, b=1, b_in=0 -> ovf=0.
6. 200 random back-to-back ops with random done_ready stalls -> each {b_out,d} matches the N+1-bit model ({1'b0,a} - b - b_in); no lost or duplicated results.
